mlp_feature_loader: RTL and testbench

MLP_FEATURE_LOADER -- requirements
Module: mlp_feature_loader

---
 rtl/mlp_pkg.sv | 13 +
 rtl/mlp_quant.sv | 23 ++
 rtl/mlp_feature_loader.sv | 123 ++++++++++++
 tb/tb_mlp_feature_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared types and default widths for the MLP feature loader.
package mlp_pkg;
  localparam int NUM_FEAT_D = 8;
  localparam int RAW_W_D    = 8;
  localparam int FEAT_W_D   = 4;
  localparam int CLS_W      = 2;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OUT    = 2'd2
  } state_e;
endpackage

// File: rtl/mlp_quant.sv
// Combinational raw-sample to feature quantizer.
// Truncates by default; QUANT_ROUND_EN selects round-to-nearest with saturation.
module mlp_quant #(
  parameter int RAW_W  = 8,
  parameter int FEAT_W = 4
) (
  input  logic [RAW_W-1:0]  raw_i,
  output logic [FEAT_W-1:0] q_o
);
  localparam int SH = RAW_W - FEAT_W;

`ifdef QUANT_ROUND_EN
  localparam logic [RAW_W:0] HALF = (RAW_W+1)'(1) << (SH - 1);
  logic [RAW_W:0] sum, shr;

  // One extra bit so a rounded-up full-scale sample saturates instead of wrapping.
  assign sum = {1'b0, raw_i} + HALF;
  assign shr = sum >> SH;
  assign q_o = (|shr[RAW_W:FEAT_W]) ? '1 : shr[FEAT_W-1:0];
`else
  assign q_o = FEAT_W'(raw_i >> SH);
`endif
endmodule

// File: rtl/mlp_feature_loader.sv
// Collects NUM_FEAT quantized samples into feat_vec, waits for the external
// classifier to settle, then presents its class. Optional macro: QUANT_ROUND_EN.
module mlp_feature_loader
  import mlp_pkg::*;
#(
  parameter int NUM_FEAT   = NUM_FEAT_D,
  parameter int RAW_W      = RAW_W_D,
  parameter int FEAT_W     = FEAT_W_D,
  parameter int SETTLE_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [RAW_W-1:0]           s_data,
  input  logic                       s_last,
  output logic [NUM_FEAT*FEAT_W-1:0] feat_vec,
  input  logic [CLS_W-1:0]           cls_in,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [CLS_W-1:0]           m_class,
  output logic                       err_frame,
  output logic [15:0]                frame_cnt
);
  localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);
  localparam logic [3:0] SETTLE_END = 4'(SETTLE_CYC);

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [NUM_FEAT*FEAT_W-1:0] feat_q, feat_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic                       m_valid_q, m_valid_d;
  logic [CLS_W-1:0]           m_class_q, m_class_d;
  logic                       err_q, err_d;
  logic [15:0]                frame_cnt_q, frame_cnt_d;
  logic [FEAT_W-1:0]          q_feat;

  mlp_quant #(.RAW_W(RAW_W), .FEAT_W(FEAT_W)) u_quant (
    .raw_i (s_data),
    .q_o   (q_feat)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    feat_d      = feat_q;
    cnt_d       = cnt_q;
    m_valid_d   = m_valid_q;
    m_class_d   = m_class_q;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_LOAD: begin
        if (s_valid) begin
          if (idx_q == LAST_IDX) begin
            feat_d[idx_q*FEAT_W +: FEAT_W] = q_feat;
            err_d   = ~s_last;
            idx_d   = '0;
            cnt_d   = '0;
            state_d = ST_SETTLE;
          end else if (s_last) begin
            // Short frame: drop it, keep the vector as it stands.
            err_d = 1'b1;
            idx_d = '0;
          end else begin
            feat_d[idx_q*FEAT_W +: FEAT_W] = q_feat;
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_SETTLE: begin
        // Exit at SETTLE_CYC so m_valid rises SETTLE_CYC+1 edges after the last beat.
        if (cnt_q == SETTLE_END) begin
          m_class_d = cls_in;
          m_valid_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_OUT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          m_valid_d   = 1'b0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          idx_d       = '0;
          state_d     = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      idx_q       <= '0;
      feat_q      <= '0;
      cnt_q       <= '0;
      m_valid_q   <= 1'b0;
      m_class_q   <= '0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      feat_q      <= feat_d;
      cnt_q       <= cnt_d;
      m_valid_q   <= m_valid_d;
      m_class_q   <= m_class_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign s_ready   = (state_q == ST_LOAD);
  assign feat_vec  = feat_q;
  assign m_valid   = m_valid_q;
  assign m_class   = m_class_q;
  assign err_frame = err_q;
  assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_mlp_feature_loader.sv
// Directed bench for mlp_feature_loader with a frame-level reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_mlp_feature_loader;
  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = '0;
  logic        s_last = 1'b0;
  logic [31:0] feat_vec;
  logic [1:0]  cls_in;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [1:0]  m_class;
  logic        err_frame;
  logic [15:0] frame_cnt;

  int nvec = 0;
  int nerr = 0;
  bit cmp_en = 1'b1;
  bit preload = 1'b0;
  logic [1:0] noise = '0;

  mlp_feature_loader #(.NUM_FEAT(8), .RAW_W(8), .FEAT_W(4), .SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .feat_vec(feat_vec), .cls_in(cls_in), .m_valid(m_valid),
    .m_ready(m_ready), .m_class(m_class), .err_frame(err_frame), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Toy external classifier; noise makes the capture cycle of m_class observable.
  function automatic logic [1:0] toy(input logic [31:0] f);
    return f[1:0] ^ f[5:4] ^ f[31:30];
  endfunction
  assign cls_in = toy(feat_vec) ^ noise;
  always @(negedge clk) noise <= noise + 2'd1;

  function automatic logic [3:0] quant(input logic [7:0] r);
    int v;
`ifdef QUANT_ROUND_EN
    v = (int'(r) + 8) / 16;
    if (v > 15) v = 15;
`else
    v = int'(r) / 16;
`endif
    return v[3:0];
  endfunction

  // Reference model: frame-level view (beats collected, edges left to wait, result held).
  int          nbeats = 0;
  int          wait_cnt = 0;
  logic [31:0] mfeat = '0;
  logic        mvalid = 1'b0;
  logic [1:0]  mclass = '0;
  logic        merr = 1'b0;
  logic [15:0] mcnt = '0;
  wire exp_ready = !mvalid && (wait_cnt == 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nbeats <= 0; wait_cnt <= 0; mfeat <= '0; mvalid <= 1'b0;
      mclass <= '0; merr <= 1'b0; mcnt <= '0;
    end else begin
      merr <= 1'b0;
      if (preload) mcnt <= 16'hFFFF;
      if (mvalid) begin
        if (m_ready) begin mvalid <= 1'b0; mcnt <= mcnt + 16'd1; end
      end else if (wait_cnt > 0) begin
        if (wait_cnt == 1) begin mvalid <= 1'b1; mclass <= toy(mfeat) ^ noise; end
        wait_cnt <= wait_cnt - 1;
      end else if (s_valid) begin
        if (nbeats == 7) begin
          mfeat[nbeats*4 +: 4] <= quant(s_data);
          nbeats <= 0; wait_cnt <= SETTLE + 1; merr <= !s_last;
        end else if (s_last) begin
          merr <= 1'b1; nbeats <= 0;
        end else begin
          mfeat[nbeats*4 +: 4] <= quant(s_data);
          nbeats <= nbeats + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model s_ready", 32'(s_ready), 32'(exp_ready));
      chk("model feat_vec", feat_vec, mfeat);
      chk("model m_valid", 32'(m_valid), 32'(mvalid));
      if (mvalid) chk("model m_class", 32'(m_class), 32'(mclass));
      chk("model err_frame", 32'(err_frame), 32'(merr));
      chk("model frame_cnt", 32'(frame_cnt), 32'(mcnt));
    end
  end

  // Present one beat and return #1 after the edge that accepted it.
  task automatic beat(input logic [7:0] d, input logic last);
    int g = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    while (!s_ready && g < 50) begin @(posedge clk); #1; g++; end
    if (g == 50) chk("beat timeout", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_mvalid();
    int g = 0;
    while (!m_valid && g < 40) begin @(posedge clk); #1; g++; end
    if (g == 40) chk("m_valid timeout", 32'(m_valid), 32'd1);
  endtask

  task automatic ramp_frame(input logic [7:0] base);
    for (int i = 0; i < 8; i++) beat(base + 8'(8'h10 * i), i == 7);
  endtask

  logic [31:0] rnd_exp;
  logic [3:0]  nib18_exp;
  logic [1:0]  cls_hold;

  initial begin
`ifdef QUANT_ROUND_EN
    rnd_exp = 32'hF321012F; nib18_exp = 4'h2;
`else
    rnd_exp = 32'hF321001F; nib18_exp = 4'h1;
`endif
    repeat (3) @(posedge clk); #1;
    chk("reset feat_vec", feat_vec, 32'h0);
    chk("reset m_valid", 32'(m_valid), 32'd0);
    chk("reset err_frame", 32'(err_frame), 32'd0);
    chk("reset frame_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready after reset", 32'(s_ready), 32'd1);

    // Basic frame and latency
    ramp_frame(8'h10);
    chk("ramp feat_vec", feat_vec, 32'h87654321);
    @(posedge clk); #1; chk("lat edge+1", 32'(m_valid), 32'd0);
    @(posedge clk); #1; chk("lat edge+2", 32'(m_valid), 32'd0);
    @(posedge clk); #1; chk("lat edge+3", 32'(m_valid), 32'd1);
    @(posedge clk); #1;
    chk("frame1 cnt", 32'(frame_cnt), 32'd1);
    chk("frame1 m_valid clr", 32'(m_valid), 32'd0);

    // Short frame: s_last on beat 3
    beat(8'hA0, 1'b0); beat(8'hB0, 1'b0); beat(8'hC0, 1'b0); beat(8'hD0, 1'b1);
    chk("short err pulse", 32'(err_frame), 32'd1);
    chk("short feat kept", feat_vec, 32'h87654CBA);
    chk("short cnt kept", 32'(frame_cnt), 32'd1);
    @(posedge clk); #1;
    chk("short err clears", 32'(err_frame), 32'd0);
    ramp_frame(8'h20);
    chk("after short feat", feat_vec, 32'h98765432);
    wait_mvalid();
    @(posedge clk); #1;
    chk("frame2 cnt", 32'(frame_cnt), 32'd2);

    // Quantization edges plus back-pressure in OUT
    m_ready = 1'b0;
    beat(8'hF8, 1'b0); beat(8'h18, 1'b0); beat(8'h08, 1'b0); beat(8'h07, 1'b0);
    beat(8'h17, 1'b0); beat(8'h27, 1'b0); beat(8'h37, 1'b0); beat(8'hFF, 1'b1);
    chk("quant F8 nibble", 32'(feat_vec[3:0]), 32'hF);
    chk("quant 18 nibble", 32'(feat_vec[7:4]), 32'(nib18_exp));
    chk("quant vector", feat_vec, rnd_exp);
    wait_mvalid();
    cls_hold = m_class;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold m_valid", 32'(m_valid), 32'd1);
      chk("hold m_class", 32'(m_class), 32'(cls_hold));
      chk("hold feat_vec", feat_vec, rnd_exp);
      chk("hold s_ready", 32'(s_ready), 32'd0);
    end
    chk("hold cnt", 32'(frame_cnt), 32'd2);
    m_ready = 1'b1;
    @(posedge clk); #1;
    chk("release cnt", 32'(frame_cnt), 32'd3);

    // Counter wrap via preload
    cmp_en = 1'b0; preload = 1'b1;
    force dut.frame_cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.frame_cnt_q;
    preload = 1'b0; cmp_en = 1'b1;
    chk("preload cnt", 32'(frame_cnt), 32'hFFFF);
    ramp_frame(8'h10);
    wait_mvalid();
    @(posedge clk); #1;
    chk("wrap cnt", 32'(frame_cnt), 32'h0);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 5; i++) beat(8'h40 + 8'(i), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async feat_vec", feat_vec, 32'h0);
    chk("async s_ready", 32'(s_ready), 32'd1);
    chk("async m_valid", 32'(m_valid), 32'd0);
    chk("async m_class", 32'(m_class), 32'd0);
    chk("async err", 32'(err_frame), 32'd0);
    chk("async cnt", 32'(frame_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ramp_frame(8'h10);
    chk("post-reset feat", feat_vec, 32'h87654321);
    wait_mvalid();
    @(posedge clk); #1;
    chk("post-reset cnt", 32'(frame_cnt), 32'd1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
